// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase controller: mode codes, controller
// state encoding and a small binary-to-BCD helper for the countdown display.
package traffic_pkg;

    // Board switch encoding of the operating mode.
    localparam logic [1:0] MODE_DARK    = 2'b00;
    localparam logic [1:0] MODE_NORMAL  = 2'b01;
    localparam logic [1:0] MODE_FLASH_R = 2'b10;
    localparam logic [1:0] MODE_FLASH_Y = 2'b11;

    typedef enum logic [2:0] {
        StDark,
        StFlash,
        StAllred,
        StGreen,
        StWalk,
        StPedClear,
        StYellow
    } state_t;

    // Two-digit BCD of a value in 0..99: {tens, units}.
    function automatic logic [7:0] bin_to_bcd(input logic [6:0] value);
        return {4'(value / 7'd10), 4'(value % 7'd10)};
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Timing-tick prescaler.
//   clock   : system clock
//   resetn  : asynchronous active-low reset
//   restart : synchronous restart, count returns to 0 on the next edge
//   tick    : one-cycle pulse while the count sits at TICK_DIV-1
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic clock,
    input  logic resetn,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q, count_d;

    assign tick = (count_q == LAST);

    always_comb begin
        count_d = count_q + CW'(1);
        if (restart || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/traffic_phase_controller.sv
// Round-robin intersection controller for NUM_PHASES approaches with
// on-demand pedestrian service.
//   clock, resetn : clock and asynchronous active-low reset
//   mode          : 00 dark, 01 normal, 10 flash red, 11 flash yellow
//   ped_req       : pedestrian push-buttons (level), one per phase
//   veh_*         : vehicle red/yellow/green lamps per phase
//   ped_walk/dont : pedestrian lamps per phase; ped_beep audible cue
//   ped_count     : BCD clearance countdown of the served phase, else 0
//   phase         : currently served phase
// All lamp outputs are registered from the state of the previous cycle.
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int unsigned NUM_PHASES      = 2,
    parameter int unsigned TICK_DIV        = 50000000,
    parameter int unsigned GREEN_TICKS     = 10,
    parameter int unsigned WALK_TICKS      = 5,
    parameter int unsigned PED_CLEAR_TICKS = 15,
    parameter int unsigned YELLOW_TICKS    = 3,
    parameter int unsigned ALLRED_TICKS    = 1,
    localparam int unsigned PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [1:0]            mode,
    input  logic [NUM_PHASES-1:0] ped_req,
    output logic [NUM_PHASES-1:0] veh_red,
    output logic [NUM_PHASES-1:0] veh_yellow,
    output logic [NUM_PHASES-1:0] veh_green,
    output logic [NUM_PHASES-1:0] ped_walk,
    output logic [NUM_PHASES-1:0] ped_dont,
    output logic [NUM_PHASES-1:0] ped_beep,
    output logic [7:0]            ped_count,
    output logic [PW-1:0]         phase
);

    localparam int unsigned CW = 8;

    state_t                state_q, state_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_PHASES-1:0] latch_q, latch_d;
    logic                  flash_q, flash_d;
    logic                  yel_q, yel_d;
    logic                  tick, restart, last_tick, normal_state;

    logic [NUM_PHASES-1:0] sel;
    logic [NUM_PHASES-1:0] red_d, yellow_d, green_d, walk_d, dont_d, beep_d;
    logic [NUM_PHASES-1:0] red_q, yellow_q, green_q, walk_q, dont_q, beep_q;
    logic [7:0]            count_d, count_q;
    logic [PW-1:0]         phase_out_q;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clock  (clock),
        .resetn (resetn),
        .restart(restart),
        .tick   (tick)
    );

    // Next-state, duration counter and pedestrian latches.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        latch_d      = latch_q;
        flash_d      = flash_q ^ tick;
        yel_d        = yel_q;
        last_tick    = tick && (cnt_q == '0);
        normal_state = (state_q != StDark) && (state_q != StFlash);

        if (normal_state) begin
            latch_d = latch_q | ped_req;
        end

        if (mode == MODE_FLASH_R) begin
            yel_d = 1'b0;
        end else if (mode == MODE_FLASH_Y) begin
            yel_d = 1'b1;
        end

        if (mode != MODE_NORMAL) begin
            state_d = (mode == MODE_DARK) ? StDark : StFlash;
            latch_d = '0;
        end else begin
            unique case (state_q)
                StDark, StFlash: begin
                    state_d = StAllred;
                    phase_d = '0;
                end
                StAllred: if (last_tick) state_d = latch_q[phase_q] ? StWalk : StGreen;
                StGreen: if (last_tick) state_d = StYellow;
                StWalk: if (last_tick) state_d = StPedClear;
                StPedClear: if (last_tick) state_d = StYellow;
                StYellow: begin
                    if (last_tick) begin
                        state_d = StAllred;
                        phase_d = (phase_q == PW'(NUM_PHASES - 1)) ? '0 : phase_q + PW'(1);
                    end
                end
                default: state_d = StDark;
            endcase
            // Serving the walk consumes the request; a same-cycle press is lost.
            if (state_d == StWalk && state_q != StWalk) begin
                latch_d[phase_d] = 1'b0;
            end
        end

        restart = (state_d != state_q);
        if (restart) begin
            case (state_d)
                StAllred:   cnt_d = CW'(ALLRED_TICKS - 1);
                StGreen:    cnt_d = CW'(GREEN_TICKS - 1);
                StWalk:     cnt_d = CW'(WALK_TICKS - 1);
                StPedClear: cnt_d = CW'(PED_CLEAR_TICKS - 1);
                StYellow:   cnt_d = CW'(YELLOW_TICKS - 1);
                default:    cnt_d = '0;
            endcase
        end else if (tick && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Lamp decode from the current state; registered below.
    always_comb begin
        sel      = '0;
        sel[phase_q] = 1'b1;
        red_d    = '0;
        yellow_d = '0;
        green_d  = '0;
        walk_d   = '0;
        dont_d   = '0;
        beep_d   = '0;
        count_d  = '0;
        unique case (state_q)
            StDark: begin
            end
            StFlash: begin
                if (yel_q) yellow_d = {NUM_PHASES{flash_q}};
                else       red_d    = {NUM_PHASES{flash_q}};
            end
            StAllred: begin
                red_d  = '1;
                dont_d = '1;
            end
            StGreen: begin
                red_d   = ~sel;
                green_d = sel;
                dont_d  = '1;
            end
            StWalk: begin
                red_d   = ~sel;
                green_d = sel;
                walk_d  = sel;
                dont_d  = ~sel;
            end
            StPedClear: begin
                red_d   = ~sel;
                green_d = sel;
                dont_d  = ~sel | (flash_q ? sel : '0);
                beep_d  = flash_q ? sel : '0;
                count_d = bin_to_bcd(7'(cnt_q + CW'(1)));
            end
            StYellow: begin
                red_d    = ~sel;
                yellow_d = sel;
                dont_d   = '1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StDark;
            phase_q <= '0;
            cnt_q   <= '0;
            latch_q <= '0;
            flash_q <= 1'b0;
            yel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            latch_q <= latch_d;
            flash_q <= flash_d;
            yel_q   <= yel_d;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            red_q       <= '0;
            yellow_q    <= '0;
            green_q     <= '0;
            walk_q      <= '0;
            dont_q      <= '0;
            beep_q      <= '0;
            count_q     <= '0;
            phase_out_q <= '0;
        end else begin
            red_q       <= red_d;
            yellow_q    <= yellow_d;
            green_q     <= green_d;
            walk_q      <= walk_d;
            dont_q      <= dont_d;
            beep_q      <= beep_d;
            count_q     <= count_d;
            phase_out_q <= phase_q;
        end
    end

    assign veh_red    = red_q;
    assign veh_yellow = yellow_q;
    assign veh_green  = green_q;
    assign ped_walk   = walk_q;
    assign ped_dont   = dont_q;
    assign ped_beep   = beep_q;
    assign ped_count  = count_q;
    assign phase      = phase_out_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Scoreboard bench: the stimulus pushes the expected output snapshots (value
// and hold length in cycles) in order; the monitor pops one entry each time
// the output vector changes and checks value and how long the previous one held.
module tb_traffic_phase_controller;

    logic       clock = 1'b0;
    logic       resetn;
    logic [1:0] mode;
    logic [1:0] ped_req;
    logic [1:0] veh_red, veh_yellow, veh_green, ped_walk, ped_dont, ped_beep;
    logic [7:0] ped_count;
    logic       phase;

    always #5 clock = ~clock;

    traffic_phase_controller #(
        .NUM_PHASES     (2),
        .TICK_DIV       (4),
        .GREEN_TICKS    (3),
        .WALK_TICKS     (2),
        .PED_CLEAR_TICKS(3),
        .YELLOW_TICKS   (2),
        .ALLRED_TICKS   (1)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .mode      (mode),
        .ped_req   (ped_req),
        .veh_red   (veh_red),
        .veh_yellow(veh_yellow),
        .veh_green (veh_green),
        .ped_walk  (ped_walk),
        .ped_dont  (ped_dont),
        .ped_beep  (ped_beep),
        .ped_count (ped_count),
        .phase     (phase)
    );

    typedef struct packed {
        logic [1:0] red;
        logic [1:0] yellow;
        logic [1:0] green;
        logic [1:0] walk;
        logic [1:0] dont;
        logic [1:0] beep;
        logic [7:0] count;
        logic       ph;
    } snap_t;

    typedef struct {
        snap_t val;
        int    dur;  // 0: hold length not checked
    } exp_t;

    exp_t  exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    logic  mon_en  = 1'b0;
    int    edge_n  = 0;
    snap_t cur;

    assign cur = {veh_red, veh_yellow, veh_green, ped_walk, ped_dont, ped_beep, ped_count, phase};

    function automatic snap_t mk(input logic [1:0] r, input logic [1:0] y, input logic [1:0] g,
                                 input logic [1:0] w, input logic [1:0] d, input logic [1:0] b,
                                 input logic [7:0] c, input logic p);
        snap_t s;
        s.red = r; s.yellow = y; s.green = g; s.walk = w;
        s.dont = d; s.beep = b; s.count = c; s.ph = p;
        return s;
    endfunction

    function automatic logic [1:0] sel_of(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction

    function automatic snap_t s_allred(input logic p);
        return mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 8'h00, p);
    endfunction
    function automatic snap_t s_green(input logic p);
        return mk(~sel_of(p), 2'b00, sel_of(p), 2'b00, 2'b11, 2'b00, 8'h00, p);
    endfunction
    function automatic snap_t s_yellow(input logic p);
        return mk(~sel_of(p), sel_of(p), 2'b00, 2'b00, 2'b11, 2'b00, 8'h00, p);
    endfunction
    function automatic snap_t s_walk(input logic p);
        return mk(~sel_of(p), 2'b00, sel_of(p), sel_of(p), ~sel_of(p), 2'b00, 8'h00, p);
    endfunction
    function automatic snap_t s_pclr(input logic p, input logic f, input logic [7:0] c);
        return mk(~sel_of(p), 2'b00, sel_of(p), 2'b00, f ? 2'b11 : ~sel_of(p),
                  f ? sel_of(p) : 2'b00, c, p);
    endfunction
    function automatic snap_t s_zero();
        return '0;
    endfunction
    function automatic snap_t s_flred();
        return mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 1'b0);
    endfunction
    function automatic snap_t s_flyel();
        return mk(2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 1'b0);
    endfunction

    task automatic push(input snap_t v, input int d);
        exp_t e;
        e.val = v;
        e.dur = d;
        exp_q.push_back(e);
    endtask

    // Wait for posedge number k after reset release, then move to the falling edge.
    task automatic after_edge(input int k);
        while (edge_n < k) begin
            @(posedge clock);
            edge_n++;
        end
        @(negedge clock);
    endtask

    task automatic check_zero(input string name);
        n_tests++;
        if (cur !== '0) begin
            n_fail++;
            $display("FAIL %s: outputs %h, expected all zero", name, cur);
        end
    endtask

    // Monitor.
    initial begin : monitor
        exp_t  cur_exp;
        snap_t last;
        logic  have_cur;
        int    hold;
        int    snap_n;
        have_cur = 1'b0;
        hold     = 0;
        snap_n   = 0;
        last     = '0;
        forever begin
            @(negedge clock);
            if (!mon_en) begin
                last     = cur;
                hold     = 0;
                have_cur = 1'b0;
            end else if (cur !== last) begin
                if (have_cur && cur_exp.dur != 0) begin
                    n_tests++;
                    if (hold != cur_exp.dur) begin
                        n_fail++;
                        $display("FAIL snap%0d hold: got %0d cycles, expected %0d",
                                 snap_n, hold, cur_exp.dur);
                    end
                end
                snap_n++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    have_cur = 1'b0;
                    $display("FAIL snap%0d unexpected output change: got %h", snap_n, cur);
                end else begin
                    cur_exp  = exp_q.pop_front();
                    have_cur = 1'b1;
                    if (cur !== cur_exp.val) begin
                        n_fail++;
                        $display("FAIL snap%0d value: got %h, expected %h",
                                 snap_n, cur, cur_exp.val);
                    end
                end
                last = cur;
                hold = 1;
            end else begin
                hold++;
            end
        end
    end

    // Stimulus.
    initial begin
        resetn  = 1'b0;
        mode    = 2'b01;
        ped_req = 2'b00;
        repeat (3) @(negedge clock);
        check_zero("reset_state");

        // Plain cycle from release.
        @(negedge clock);
        resetn = 1'b1;
        edge_n = 0;
        mon_en = 1'b1;
        push(s_allred(1'b0), 4);
        push(s_green(1'b0), 12);
        push(s_yellow(1'b0), 8);
        push(s_allred(1'b1), 4);

        // One-cycle request for phase 1 during phase 0 green.
        after_edge(8);
        ped_req[1] = 1'b1;
        push(s_walk(1'b1), 8);
        push(s_pclr(1'b1, 1'b1, 8'h03), 4);
        push(s_pclr(1'b1, 1'b0, 8'h02), 4);
        push(s_pclr(1'b1, 1'b1, 8'h01), 4);
        push(s_yellow(1'b1), 8);
        after_edge(9);
        ped_req[1] = 1'b0;

        // Phase 0 request held through its own walk: served twice.
        after_edge(40);
        ped_req[0] = 1'b1;
        push(s_allred(1'b0), 4);
        push(s_walk(1'b0), 8);
        push(s_pclr(1'b0, 1'b1, 8'h03), 4);
        push(s_pclr(1'b0, 1'b0, 8'h02), 4);
        push(s_pclr(1'b0, 1'b1, 8'h01), 4);
        push(s_yellow(1'b0), 8);
        push(s_allred(1'b1), 4);
        push(s_green(1'b1), 12);
        push(s_yellow(1'b1), 8);
        push(s_allred(1'b0), 4);
        push(s_walk(1'b0), 8);
        after_edge(72);
        ped_req[0] = 1'b0;

        // Flash yellow in the middle of clearance, then back to normal.
        after_edge(120);
        push(s_pclr(1'b0, 1'b1, 8'h03), 4);
        push(s_pclr(1'b0, 1'b0, 8'h02), 2);
        push(s_zero(), 4);
        push(s_flyel(), 4);
        push(s_zero(), 2);
        after_edge(130);
        mode = 2'b11;
        after_edge(140);
        mode = 2'b01;
        push(s_allred(1'b0), 4);
        push(s_green(1'b0), 6);

        // Dark for 20 cycles, then flash red.
        after_edge(150);
        mode = 2'b00;
        push(s_zero(), 20);
        push(s_flred(), 4);
        push(s_zero(), 4);
        push(s_flred(), 4);
        push(s_zero(), 4);
        after_edge(170);
        mode = 2'b10;

        // Normal again, then asynchronous reset in yellow.
        after_edge(186);
        mode = 2'b01;
        push(s_allred(1'b0), 4);
        push(s_green(1'b0), 12);
        push(s_yellow(1'b0), 0);
        after_edge(206);
        #1;
        mon_en = 1'b0;
        resetn = 1'b0;
        #1;
        check_zero("async_reset");
        repeat (2) @(negedge clock);
        check_zero("held_reset");

        push(s_allred(1'b0), 4);
        push(s_green(1'b0), 12);
        push(s_yellow(1'b0), 8);
        push(s_allred(1'b1), 4);
        push(s_green(1'b1), 0);
        @(negedge clock);
        resetn = 1'b1;
        edge_n = 0;
        mon_en = 1'b1;
        after_edge(40);

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_snapshots: %0d left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
